// File: rtl/cpu.sv
// cpu: 16-bit multicycle RISC core with an 8x16 register file, a one-bit
// shifter on the Rm operand, Z/N/V flags and a single shared memory port.
// Each instruction is sequenced by the control FSM, one state per clock.
module cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] read_data,
    output logic [1:0]  mem_cmd,
    output logic [8:0]  mem_addr,
    output logic [15:0] write_data
);

    typedef enum logic [3:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB,
        S_CALC, S_WRITE, S_LADDR, S_MREAD, S_LWRITE, S_GETD, S_MWRITE, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        I_MOVI, I_MOVR, I_ADD, I_CMP, I_AND, I_MVN, I_LDR, I_STR, I_HALT, I_NOP
    } instr_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t      state, state_next;
    instr_t      instr;

    logic [8:0]  pc;
    logic [8:0]  data_addr;
    logic [15:0] ir;
    logic [15:0] reg_a, reg_b, reg_c;
    logic [15:0] rf [8];
    logic        flag_z, flag_n, flag_v;

    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] imm8_sx, imm5_sx;
    logic [15:0] b_shifted, alu_out, cmp_diff;

    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    assign opcode  = ir[15:13];
    assign op      = ir[12:11];
    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign sh      = ir[4:3];
    assign rm      = ir[2:0];
    assign imm8_sx = {{8{ir[7]}}, ir[7:0]};
    assign imm5_sx = {{11{ir[4]}}, ir[4:0]};

    // Classify the instruction held in IR; unlisted encodings run as NOP.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        instr = I_NOP;
        case (opcode)
            3'b110: begin
                if (op == 2'b10)      instr = I_MOVI;
                else if (op == 2'b00) instr = I_MOVR;
            end
            3'b101: begin
                case (op)
                    2'b00:   instr = I_ADD;
                    2'b01:   instr = I_CMP;
                    2'b10:   instr = I_AND;
                    default: instr = I_MVN;
                endcase
            end
            3'b011:  if (op == 2'b00) instr = I_LDR;
            3'b100:  if (op == 2'b00) instr = I_STR;
            3'b111:  instr = I_HALT;
            default: instr = I_NOP;
        endcase
    end

    // Shifter on the B operand: none, LSL 1, LSR 1, ASR 1.
    always_comb begin
        b_shifted = reg_b;
        case (sh)
            2'b01:   b_shifted = {reg_b[14:0], 1'b0};
            2'b10:   b_shifted = {1'b0, reg_b[15:1]};
            2'b11:   b_shifted = {reg_b[15], reg_b[15:1]};
            default: b_shifted = reg_b;
        endcase
    end

    assign cmp_diff = reg_a - b_shifted;

    // ALU result captured into C; loads/stores use it for the effective address.
    always_comb begin
        alu_out = b_shifted;
        case (instr)
            I_ADD:        alu_out = reg_a + b_shifted;
            I_AND:        alu_out = reg_a & b_shifted;
            I_MVN:        alu_out = ~b_shifted;
            I_CMP:        alu_out = cmp_diff;
            I_LDR, I_STR: alu_out = reg_a + imm5_sx;
            default:      alu_out = b_shifted;
        endcase
    end

    // Next-state logic plus memory-port and register-write controls.
    always_comb begin
        state_next = state;
        mem_cmd    = CMD_NONE;
        mem_addr   = pc;
        rf_we      = 1'b0;
        rf_waddr   = rd;
        rf_wdata   = reg_c;
        case (state)
            S_RST: state_next = S_IF1;
            S_IF1: begin
                mem_cmd    = CMD_READ;
                state_next = S_IF2;
            end
            S_IF2: begin
                mem_cmd    = CMD_READ;
                state_next = S_UPC;
            end
            S_UPC: state_next = S_DEC;
            S_DEC: begin
                case (instr)
                    I_MOVI:                      state_next = S_WIMM;
                    I_MOVR, I_MVN:               state_next = S_GETB;
                    I_ADD, I_AND, I_CMP,
                    I_LDR, I_STR:                state_next = S_GETA;
                    I_HALT:                      state_next = S_HALT;
                    default:                     state_next = S_IF1;
                endcase
            end
            S_WIMM: begin
                rf_we      = 1'b1;
                rf_waddr   = rn;
                rf_wdata   = imm8_sx;
                state_next = S_IF1;
            end
            S_GETA: state_next = (instr == I_LDR || instr == I_STR) ? S_CALC : S_GETB;
            S_GETB: state_next = S_CALC;
            S_CALC: begin
                if (instr == I_CMP)                         state_next = S_IF1;
                else if (instr == I_LDR || instr == I_STR)  state_next = S_LADDR;
                else                                        state_next = S_WRITE;
            end
            S_WRITE: begin
                rf_we      = 1'b1;
                state_next = S_IF1;
            end
            S_LADDR: state_next = (instr == I_LDR) ? S_MREAD : S_GETD;
            S_MREAD: begin
                mem_cmd    = CMD_READ;
                mem_addr   = data_addr;
                state_next = S_LWRITE;
            end
            S_LWRITE: begin
                rf_we      = 1'b1;
                state_next = S_IF1;
            end
            S_GETD: state_next = S_MWRITE;
            S_MWRITE: begin
                mem_cmd    = CMD_WRITE;
                mem_addr   = data_addr;
                state_next = S_IF1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    // State register; reset wins over every state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // the values from before this edge, independent of statement order.
        if (reset) state <= S_RST;
        else       state <= state_next;
    end

    // Datapath registers, flags and the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            reg_c      <= '0;
            data_addr  <= '0;
            write_data <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
            // NOTE: the register file is small and architecturally defined as
            // zero after reset, so it is cleared here like ordinary flops.
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_IF2:  ir    <= read_data;
                S_UPC:  pc    <= pc + 9'd1;
                S_GETA: reg_a <= rf[rn];
                S_GETB: reg_b <= rf[rm];
                S_CALC: begin
                    reg_c <= alu_out;
                    if (instr == I_CMP) begin
                        flag_z <= (cmp_diff == 16'd0);
                        flag_n <= cmp_diff[15];
                        flag_v <= (reg_a[15] != b_shifted[15]) && (cmp_diff[15] != reg_a[15]);
                    end
                end
                S_LADDR: data_addr <= reg_c[8:0];
                // Memory data is only valid while the load address is driven,
                // so it is held in C for the following register-write cycle.
                S_MREAD: reg_c      <= read_data;
                S_GETD:  write_data <= rf[rd];
                default: ;
            endcase
            if (rf_we) rf[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed and randomized checks of the cpu core against an
// instruction-level model that predicts every bus cycle.
module tb_cpu;

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] read_data;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;

    logic [15:0] mem [512];

    // Instruction-level reference model state
    logic [15:0] m_mem [512];
    logic [15:0] m_r   [8];
    logic [8:0]  m_pc;
    logic        m_z, m_n, m_v, m_halted;
    logic [15:0] m_wd;
    cyc_t        exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    cpu dut (
        .clk        (clk),
        .reset      (reset),
        .read_data  (read_data),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data)
    );

    always #5 clk = ~clk;

    assign read_data = mem[mem_addr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_movi(input int rn, input int imm);
        return {3'b110, 2'b10, 3'(rn), 8'(imm)};
    endfunction

    function automatic logic [15:0] enc_alu(input int op, input int rn, input int rd, input int sh, input int rm);
        return {3'b101, 2'(op), 3'(rn), 3'(rd), 2'(sh), 3'(rm)};
    endfunction

    function automatic logic [15:0] enc_movr(input int rd, input int sh, input int rm);
        return {3'b110, 2'b00, 3'b000, 3'(rd), 2'(sh), 3'(rm)};
    endfunction

    function automatic logic [15:0] enc_mem(input int opc, input int rn, input int rd, input int imm);
        return {3'(opc), 2'b00, 3'(rn), 3'(rd), 5'(imm)};
    endfunction

    function automatic logic [15:0] shift1(input logic [15:0] v, input logic [1:0] sh);
        case (sh)
            2'd1:    return v << 1;
            2'd2:    return v >> 1;
            2'd3:    return 16'($signed(v) >>> 1);
            default: return v;
        endcase
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        case ($urandom_range(0, 10))
            0, 1, 2: w = enc_movi($urandom_range(0, 7), $urandom_range(0, 255));
            3:       w = enc_movr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7));
            4, 5, 6, 7:
                     w = enc_alu($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                                 $urandom_range(0, 3), $urandom_range(0, 7));
            8:       w = enc_mem(3, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
            9:       w = enc_mem(4, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
            default: begin
                w = 16'($urandom);
                if (w[15:13] == 3'b111) w[15] = 1'b0;
            end
        endcase
        return w;
    endfunction

    task automatic push(input logic [1:0] cmd, input logic [8:0] addr);
        cyc_t c;
        c.cmd  = cmd;
        c.addr = addr;
        c.wd   = m_wd;
        exp_q.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(NONE, m_pc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_pc = '0; m_z = 0; m_n = 0; m_v = 0; m_wd = '0; m_halted = 0;
        exp_q.delete();
    endtask

    // Execute one instruction and queue the bus cycles it must produce.
    task automatic model_step();
        logic [15:0] ir, s, res;
        logic [8:0]  pc0, ea;
        logic [2:0]  rn, rd, rm;
        int a, b, d;
        if (m_halted) begin
            push(NONE, m_pc);
            return;
        end
        pc0  = m_pc;
        ir   = m_mem[pc0];
        m_pc = pc0 + 9'd1;
        push(READ, pc0);
        push(READ, pc0);
        push(NONE, pc0);
        push(NONE, m_pc);
        rn = ir[10:8];
        rd = ir[7:5];
        rm = ir[2:0];
        s  = shift1(m_r[rm], ir[4:3]);
        ea = 9'(m_r[rn] + {{11{ir[4]}}, ir[4:0]});
        case (ir[15:13])
            3'b110: begin
                if (ir[12:11] == 2'b10) begin
                    m_r[rn] = {{8{ir[7]}}, ir[7:0]};
                    idle(1);
                end else if (ir[12:11] == 2'b00) begin
                    m_r[rd] = s;
                    idle(3);
                end
            end
            3'b101: begin
                case (ir[12:11])
                    2'b00: begin m_r[rd] = m_r[rn] + s; idle(4); end
                    2'b01: begin
                        res = m_r[rn] - s;
                        a   = int'($signed(m_r[rn]));
                        b   = int'($signed(s));
                        d   = a - b;
                        m_z = (res == 16'd0);
                        m_n = res[15];
                        m_v = (d > 32767) || (d < -32768);
                        idle(3);
                    end
                    2'b10: begin m_r[rd] = m_r[rn] & s; idle(4); end
                    default: begin m_r[rd] = ~s; idle(3); end
                endcase
            end
            3'b011: begin
                if (ir[12:11] == 2'b00) begin
                    idle(3);
                    push(READ, ea);
                    m_r[rd] = m_mem[ea];
                    idle(1);
                end
            end
            3'b100: begin
                if (ir[12:11] == 2'b00) begin
                    idle(4);
                    m_wd = m_r[rd];
                    push(WRITE, ea);
                    m_mem[ea] = m_wd;
                end
            end
            3'b111:  m_halted = 1'b1;
            default: ;
        endcase
    endtask

    // Compare n queued cycles at the falling edge; the bench memory takes DUT writes.
    task automatic drain_count(input int n);
        cyc_t e;
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            @(negedge clk);
            cyc++;
            check("mem_cmd",    16'(mem_cmd),  16'(e.cmd));
            check("mem_addr",   16'(mem_addr), 16'(e.addr));
            check("write_data", write_data,    e.wd);
            if (mem_cmd == WRITE) mem[mem_addr] = write_data;
        end
    endtask

    task automatic drain();
        drain_count(exp_q.size());
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            drain();
        end
    endtask

    task automatic load(input int addr, input logic [15:0] w);
        mem[addr]   = w;
        m_mem[addr] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) load(i, 16'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rst_cmd",  16'(mem_cmd),  16'(NONE));
        check("rst_addr", 16'(mem_addr), 16'd0);
        check("rst_wd",   write_data,    16'd0);
        check("rst_r7",   dut.rf[7],     16'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_arch(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), dut.rf[i], m_r[i]);
        check({tag, "_pc"}, 16'(dut.pc), 16'(m_pc));
        check({tag, "_zn"}, 16'({dut.flag_z, dut.flag_n, dut.flag_v}), 16'({m_z, m_n, m_v}));
    endtask

    task automatic random_run(input int n_instr);
        for (int i = 0; i < 512; i++) load(i, rand_instr());
        do_reset();
        for (int k = 0; k < n_instr && !m_halted; k++) run(1);
        if (m_halted) run(5);
        check_arch("rand");
    endtask

    initial begin
        reset = 1'b1;

        // Directed program
        clear_mem();
        load(0,  enc_movi(0, 7));
        load(1,  enc_movi(1, 2));
        load(2,  enc_alu(0, 1, 2, 1, 0));
        load(3,  enc_mem(4, 1, 2, 1));
        load(4,  enc_mem(3, 1, 3, -1));
        load(5,  enc_movi(4, -1));
        load(6,  enc_movi(5, 1));
        load(7,  enc_alu(1, 5, 0, 0, 4));
        load(8,  enc_alu(1, 4, 0, 0, 4));
        load(9,  enc_movi(6, -128));
        load(10, 16'hE000);
        do_reset();

        run(1);
        check("r0_movi",  dut.rf[0],      16'd7);
        check("pc_first", 16'(dut.pc),    16'd1);
        check("wd_first", write_data,     16'd0);
        run(1);
        // Word 1 has been fetched already; reuse it as load data.
        load(1, 16'h1234);
        run(1);
        check("r2_add",   dut.rf[2],      16'd16);
        check("wd_add",   write_data,     16'd0);
        run(1);
        check("mem3_str", mem[3],         16'd16);
        check("wd_str",   write_data,     16'd16);
        run(1);
        check("r3_ldr",   dut.rf[3],      16'h1234);
        run(3);
        check("cmp1_flags", 16'({dut.flag_z, dut.flag_n, dut.flag_v}), 16'b000);
        run(1);
        check("cmp2_z",   16'(dut.flag_z), 16'd1);
        run(1);
        check("r6_neg",   dut.rf[6],      16'hFF80);
        run(1);
        run(20);
        check("halt_pc",  16'(dut.pc),    16'd11);
        check_arch("dir");

        // Reset during the data fetch of a store must abort it.
        clear_mem();
        load(0, enc_movi(0, 5));
        load(1, enc_mem(4, 0, 0, 0));
        load(2, enc_movi(1, 9));
        load(3, enc_mem(4, 0, 1, 1));
        do_reset();
        run(3);
        check("wd_before", write_data, 16'd5);
        model_step();
        drain_count(8);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            cyc++;
            check("abort_cmd", 16'(mem_cmd),  16'(NONE));
            check("abort_pc",  16'(dut.pc),   16'd0);
            check("abort_wd",  write_data,    16'd0);
        end
        check("abort_mem6", mem[6], 16'd0);

        // Randomized programs against the model
        for (int r = 0; r < 3; r++) random_run(350);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
